// File: rtl/dcache_wb_buffer_if.sv
// Shared line/address types and the bus bundle between the dcache writeback port,
// the write-back buffer and the memory arbiter write port.
package dcache_wb_pkg;
  localparam int TAG_BITS = 13;

  typedef struct packed {
    logic                valid;
    logic [15:0]         zeros;
    logic [TAG_BITS-1:0] tag;
    logic [2:0]          block_offset;
  } I_ADDR_PACKET;

  typedef logic [63:0] MEM_BLOCK;
endpackage

interface dcache_wb_buffer_if #(
  parameter int DEPTH    = 4,
  parameter int CNT_BITS = $clog2(DEPTH) + 1
);
  logic                       wb_valid;
  dcache_wb_pkg::I_ADDR_PACKET wb_addr;
  dcache_wb_pkg::MEM_BLOCK     wb_data;
  logic                       full;
  logic [CNT_BITS-1:0]        count;
  logic                       overflow;
  logic                       mem_wr_valid;
  dcache_wb_pkg::I_ADDR_PACKET mem_wr_addr;
  dcache_wb_pkg::MEM_BLOCK     mem_wr_data;
  logic                       mem_wr_accepted;
  dcache_wb_pkg::I_ADDR_PACKET snoop_addr;
  logic                       snoop_hit;
  dcache_wb_pkg::MEM_BLOCK     snoop_data;
  logic                       flush_req;
  logic                       flush_busy;
  logic                       flush_done;

  modport master (
    output wb_valid, wb_addr, wb_data, mem_wr_accepted, snoop_addr, flush_req,
    input  full, count, overflow, mem_wr_valid, mem_wr_addr, mem_wr_data,
           snoop_hit, snoop_data, flush_busy, flush_done
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, mem_wr_accepted, snoop_addr, flush_req,
    output full, count, overflow, mem_wr_valid, mem_wr_addr, mem_wr_data,
           snoop_hit, snoop_data, flush_busy, flush_done
  );
endinterface

// File: rtl/dcache_wb_buffer.sv
// Circular write-back buffer between the dcache dirty-eviction port and the memory arbiter,
// with read-miss snooping and a flush FSM. Optional in-place coalescing: DCACHE_WB_COALESCE_EN.
module dcache_wb_buffer #(
  parameter int DEPTH    = 4,
  parameter int IDX_BITS = $clog2(DEPTH),
  parameter int CNT_BITS = $clog2(DEPTH) + 1
) (
  input  logic                 clock,
  input  logic                 reset,
  dcache_wb_buffer_if.slave    bus
);
  import dcache_wb_pkg::*;

  localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } flush_state_t;

  logic [IDX_BITS-1:0] head_r;
  logic [IDX_BITS-1:0] tail_r;
  logic [CNT_BITS-1:0] count_r;
  logic [CNT_BITS-1:0] count_s;
  logic                full_r;
  logic                overflow_r;
  logic [DEPTH-1:0]    vld_r;
  logic [TAG_BITS-1:0] tag_r  [DEPTH];
  MEM_BLOCK            data_r [DEPTH];
  flush_state_t        state_r;
  flush_state_t        state_s;

  logic     mem_wr_valid_s;
  logic     deq_s;
  logic     enq_s;
  logic     drop_s;
  logic     coal_hit_s;
  logic     snoop_hit_s;
  MEM_BLOCK snoop_data_s;
  logic     flush_busy_s;
  logic     flush_done_s;

  // Head handshake, allocation and drop decisions for this cycle
  always_comb begin
    mem_wr_valid_s = (count_r != {CNT_BITS{1'b0}});
    deq_s          = mem_wr_valid_s && bus.mem_wr_accepted;
    enq_s          = bus.wb_valid && !coal_hit_s && ((count_r < DEPTH_CNT) || deq_s);
    drop_s         = bus.wb_valid && !coal_hit_s && (count_r == DEPTH_CNT) && !deq_s;
    count_s        = count_r + CNT_BITS'(enq_s) - CNT_BITS'(deq_s);
  end

`ifdef DCACHE_WB_COALESCE_EN
  logic [DEPTH-1:0]    coal_match_s;
  logic [IDX_BITS-1:0] coal_idx_s;

  // Non-head entry with the same tag absorbs the incoming line; head may already be in flight
  always_comb begin
    coal_match_s = {DEPTH{1'b0}};
    coal_idx_s   = {IDX_BITS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      coal_match_s[i] = vld_r[i] && (IDX_BITS'(i) != head_r) && (tag_r[i] == bus.wb_addr.tag);
      coal_idx_s      = coal_idx_s | (IDX_BITS'(i) & {IDX_BITS{coal_match_s[i]}});
    end
    coal_hit_s = bus.wb_valid && (coal_match_s != {DEPTH{1'b0}});
  end
`else
  // Every accepted writeback allocates its own entry
  always_comb begin
    coal_hit_s = 1'b0;
  end
`endif

  // Entry storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_r     <= {IDX_BITS{1'b0}};
      tail_r     <= {IDX_BITS{1'b0}};
      count_r    <= {CNT_BITS{1'b0}};
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
      vld_r      <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        tag_r[i]  <= {TAG_BITS{1'b0}};
        data_r[i] <= 64'h0;
      end
    end else begin
      if (deq_s) begin
        vld_r[head_r] <= 1'b0;
        head_r        <= head_r + IDX_BITS'(1);
      end
      // Placed after the dequeue so a full-buffer swap leaves the reused slot valid
      if (enq_s) begin
        vld_r[tail_r]  <= 1'b1;
        tag_r[tail_r]  <= bus.wb_addr.tag;
        data_r[tail_r] <= bus.wb_data;
        tail_r         <= tail_r + IDX_BITS'(1);
      end
`ifdef DCACHE_WB_COALESCE_EN
      if (coal_hit_s) begin
        data_r[coal_idx_s] <= bus.wb_data;
      end
`endif
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
      count_r <= count_s;
      full_r  <= (count_s == DEPTH_CNT);
    end
  end

  // Snoop walks oldest to youngest so the youngest matching entry wins
  always_comb begin
    logic [IDX_BITS-1:0] idx_v;
    logic                hit_v;
    snoop_hit_s  = 1'b0;
    snoop_data_s = 64'h0;
    idx_v        = head_r;
    hit_v        = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      idx_v        = head_r + IDX_BITS'(k);
      hit_v        = vld_r[idx_v] && bus.snoop_addr.valid && (tag_r[idx_v] == bus.snoop_addr.tag);
      snoop_hit_s  = snoop_hit_s | hit_v;
      snoop_data_s = hit_v ? data_r[idx_v] : snoop_data_s;
    end
  end

  // Head entry presented to the arbiter, zeroed when nothing is pending
  always_comb begin
    bus.mem_wr_addr = '0;
    bus.mem_wr_data = 64'h0;
    if (mem_wr_valid_s) begin
      bus.mem_wr_addr.valid = 1'b1;
      bus.mem_wr_addr.tag   = tag_r[head_r];
      bus.mem_wr_data       = data_r[head_r];
    end else begin
      bus.mem_wr_addr = '0;
      bus.mem_wr_data = 64'h0;
    end
  end

  // Flush state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Flush next-state and status decode; writebacks arriving mid-flush extend it
  always_comb begin
    state_s      = state_r;
    flush_busy_s = 1'b0;
    flush_done_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.flush_req) begin
          state_s = FLUSH;
        end else begin
          state_s = IDLE;
        end
      end
      FLUSH: begin
        flush_busy_s = 1'b1;
        if ((count_r == {CNT_BITS{1'b0}}) && !enq_s) begin
          state_s = DONE;
        end else begin
          state_s = FLUSH;
        end
      end
      DONE: begin
        flush_done_s = 1'b1;
        state_s      = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  assign bus.mem_wr_valid = mem_wr_valid_s;
  assign bus.count        = count_r;
  assign bus.full         = full_r;
  assign bus.overflow     = overflow_r;
  assign bus.snoop_hit    = snoop_hit_s;
  assign bus.snoop_data   = snoop_data_s;
  assign bus.flush_busy   = flush_busy_s;
  assign bus.flush_done   = flush_done_s;
endmodule

// File: tb/tb_dcache_wb_buffer.sv
// Scoreboard bench for dcache_wb_buffer: directed writebacks push expected memory writes,
// a negedge monitor pops and compares every accepted arbiter write.
module tb_dcache_wb_buffer;
  import dcache_wb_pkg::*;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [63:0]         data;
  } exp_t;

  logic clock;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   done_cnt;
  int   busy_err;
  exp_t exp_q[$];

  dcache_wb_buffer_if #(.DEPTH(4)) bus_if ();

  dcache_wb_buffer #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic I_ADDR_PACKET mk_addr(input logic [TAG_BITS-1:0] tag);
    I_ADDR_PACKET a;
    a       = '0;
    a.valid = 1'b1;
    a.tag   = tag;
    return a;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // offer a writeback and record the arbiter write it should eventually produce
  task automatic send(input logic [TAG_BITS-1:0] tag, input logic [63:0] data);
    exp_t e;
    bus_if.wb_valid = 1'b1;
    bus_if.wb_addr  = mk_addr(tag);
    bus_if.wb_data  = data;
    e.tag  = tag;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic send_nopush(input logic [TAG_BITS-1:0] tag, input logic [63:0] data);
    bus_if.wb_valid = 1'b1;
    bus_if.wb_addr  = mk_addr(tag);
    bus_if.wb_data  = data;
  endtask

  // Monitor: every accepted write must match the oldest expected entry
  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset && bus_if.mem_wr_valid && bus_if.mem_wr_accepted) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wr_unexpected: got tag %h expected no write", bus_if.mem_wr_addr.tag);
      end else begin
        e = exp_q.pop_front();
        chk("wr_tag", 64'(bus_if.mem_wr_addr.tag), 64'(e.tag));
        chk("wr_data", bus_if.mem_wr_data, e.data);
        chk("wr_addr_fmt", {bus_if.mem_wr_addr.valid, bus_if.mem_wr_addr.zeros, bus_if.mem_wr_addr.block_offset},
            {1'b1, 16'h0, 3'h0});
      end
    end
    if (bus_if.flush_done) done_cnt++;
  end

  initial begin
    n_chk = 0; n_fail = 0; done_cnt = 0; busy_err = 0;
    reset = 1'b0;
    bus_if.wb_valid = 1'b0;
    bus_if.wb_addr = '0;
    bus_if.wb_data = 64'h0;
    bus_if.mem_wr_accepted = 1'b0;
    bus_if.snoop_addr = '0;
    bus_if.flush_req = 1'b0;
    repeat (3) tick();
    chk("rst_count", 64'(bus_if.count), 64'd0);
    chk("rst_full", 64'(bus_if.full), 64'd0);
    chk("rst_overflow", 64'(bus_if.overflow), 64'd0);
    chk("rst_mem_wr_valid", 64'(bus_if.mem_wr_valid), 64'd0);
    chk("rst_mem_wr_addr", 64'(bus_if.mem_wr_addr), 64'd0);
    chk("rst_flush", 64'({bus_if.flush_busy, bus_if.flush_done}), 64'd0);
    @(negedge clock) reset = 1'b1;

    // single line, arbiter accepting, no same-cycle bypass
    bus_if.mem_wr_accepted = 1'b1;
    send(13'h1A, 64'hDEAD_BEEF_0000_0001);
    #1 chk("t1_no_bypass", 64'(bus_if.mem_wr_valid), 64'd0);
    tick();
    bus_if.wb_valid = 1'b0;
    chk("t1_count1", 64'(bus_if.count), 64'd1);
    chk("t1_valid", 64'(bus_if.mem_wr_valid), 64'd1);
    tick();
    chk("t1_count0", 64'(bus_if.count), 64'd0);

    // stall and fill, then overflow drop
    bus_if.mem_wr_accepted = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      send(13'(i), 64'h100 + 64'(i));
      tick();
    end
    bus_if.wb_valid = 1'b0;
    chk("t2_full", 64'(bus_if.full), 64'd1);
    chk("t2_count", 64'(bus_if.count), 64'd4);
    chk("t2_head", 64'(bus_if.mem_wr_addr.tag), 64'd1);
    chk("t2_no_ovf_yet", 64'(bus_if.overflow), 64'd0);
    send_nopush(13'h5, 64'h105);
    tick();
    bus_if.wb_valid = 1'b0;
    chk("t2_overflow", 64'(bus_if.overflow), 64'd1);
    chk("t2_count_kept", 64'(bus_if.count), 64'd4);
    chk("t2_head_kept", 64'(bus_if.mem_wr_addr.tag), 64'd1);
    bus_if.mem_wr_accepted = 1'b1;
    repeat (4) tick();
    bus_if.mem_wr_accepted = 1'b0;
    chk("t2_drained", 64'(bus_if.count), 64'd0);
    chk("t2_ovf_sticky", 64'(bus_if.overflow), 64'd1);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);

    reset = 1'b0;
    #2 chk("rst2_overflow", 64'(bus_if.overflow), 64'd0);
    exp_q.delete();
    @(negedge clock) reset = 1'b1;

    // full with simultaneous dequeue and enqueue, wrap order
    for (int i = 0; i < 4; i++) begin
      send(13'h11 + 13'(i), 64'h1100 + 64'(i));
      tick();
    end
    bus_if.mem_wr_accepted = 1'b1;
    send(13'h9, 64'h900);
    tick();
    bus_if.wb_valid = 1'b0;
    chk("t3_count", 64'(bus_if.count), 64'd4);
    chk("t3_full", 64'(bus_if.full), 64'd1);
    chk("t3_overflow", 64'(bus_if.overflow), 64'd0);
    repeat (4) tick();
    bus_if.mem_wr_accepted = 1'b0;
    chk("t3_drained", 64'(bus_if.count), 64'd0);

    // snoop: youngest wins, miss returns zero, same-cycle incoming line not snooped
    send(13'h7, 64'hAAAA_0000_0000_000A);
    tick();
    send(13'h7, 64'hBBBB_0000_0000_000B);
    tick();
    bus_if.wb_valid = 1'b0;
    bus_if.snoop_addr = mk_addr(13'h7);
    #1 chk("t4_hit7", 64'(bus_if.snoop_hit), 64'd1);
    chk("t4_data7", bus_if.snoop_data, 64'hBBBB_0000_0000_000B);
    bus_if.snoop_addr = mk_addr(13'h8);
    #1 chk("t4_miss8", 64'(bus_if.snoop_hit), 64'd0);
    chk("t4_data8", bus_if.snoop_data, 64'h0);
    bus_if.snoop_addr = mk_addr(13'h7);
    bus_if.snoop_addr.valid = 1'b0;
    #1 chk("t4_invalid_snoop", 64'(bus_if.snoop_hit), 64'd0);
    send(13'h55, 64'h5555);
    bus_if.snoop_addr = mk_addr(13'h55);
    #1 chk("t4_incoming_not_snooped", 64'(bus_if.snoop_hit), 64'd0);
    tick();
    bus_if.wb_valid = 1'b0;
    chk("t4_registered_hit", 64'(bus_if.snoop_hit), 64'd1);
    bus_if.snoop_addr = '0;
    bus_if.mem_wr_accepted = 1'b1;
    repeat (3) tick();
    bus_if.mem_wr_accepted = 1'b0;
    chk("t4_drained", 64'(bus_if.count), 64'd0);

    // flush of an empty buffer: FLUSH then DONE then IDLE
    bus_if.flush_req = 1'b1;
    tick();
    bus_if.flush_req = 1'b0;
    chk("t5_busy", 64'({bus_if.flush_busy, bus_if.flush_done}), 64'b10);
    tick();
    chk("t5_done", 64'({bus_if.flush_busy, bus_if.flush_done}), 64'b01);
    tick();
    chk("t5_idle", 64'({bus_if.flush_busy, bus_if.flush_done}), 64'b00);

    // flush three entries with an arbiter accepting every other cycle
    for (int i = 0; i < 3; i++) begin
      send(13'h21 + 13'(i), 64'h2100 + 64'(i));
      tick();
    end
    bus_if.wb_valid = 1'b0;
    done_cnt = 0;
    bus_if.flush_req = 1'b1;
    tick();
    bus_if.flush_req = 1'b0;
    chk("t6_busy", 64'(bus_if.flush_busy), 64'd1);
    for (int i = 0; i < 20; i++) begin
      bus_if.mem_wr_accepted = (i % 2 == 0);
      tick();
      if (bus_if.count != 0 && !bus_if.flush_busy) busy_err++;
    end
    bus_if.mem_wr_accepted = 1'b0;
    chk("t6_busy_while_pending", 64'(busy_err), 64'd0);
    chk("t6_done_pulses", 64'(done_cnt), 64'd1);
    chk("t6_count", 64'(bus_if.count), 64'd0);
    chk("t6_idle", 64'({bus_if.flush_busy, bus_if.flush_done}), 64'b00);

    // reset in the middle of a flush
    send(13'h31, 64'h3100);
    tick();
    send(13'h32, 64'h3200);
    tick();
    bus_if.wb_valid = 1'b0;
    bus_if.flush_req = 1'b1;
    tick();
    bus_if.flush_req = 1'b0;
    chk("t7_busy", 64'(bus_if.flush_busy), 64'd1);
    done_cnt = 0;
    bus_if.snoop_addr = mk_addr(13'h31);
    reset = 1'b0;
    #2;
    chk("t7_count", 64'(bus_if.count), 64'd0);
    chk("t7_flags", 64'({bus_if.full, bus_if.overflow, bus_if.mem_wr_valid, bus_if.snoop_hit}), 64'd0);
    chk("t7_addr", 64'(bus_if.mem_wr_addr), 64'd0);
    chk("t7_data", bus_if.mem_wr_data | bus_if.snoop_data, 64'h0);
    chk("t7_flush", 64'({bus_if.flush_busy, bus_if.flush_done}), 64'd0);
    exp_q.delete();
    bus_if.snoop_addr = '0;
    repeat (2) @(posedge clock);
    @(negedge clock) reset = 1'b1;
    repeat (5) tick();
    chk("t7_no_done", 64'(done_cnt), 64'd0);
    chk("t7_empty", 64'(bus_if.mem_wr_valid), 64'd0);

`ifdef DCACHE_WB_COALESCE_EN
    // coalescing into a non-head entry, head match allocates
    send(13'h3, 64'h300);
    tick();
    send(13'h4, 64'h400);
    tick();
    send_nopush(13'h4, 64'hC0C0_C0C0);
    exp_q[1].data = 64'hC0C0_C0C0;
    tick();
    bus_if.wb_valid = 1'b0;
    chk("c_count2", 64'(bus_if.count), 64'd2);
    bus_if.snoop_addr = mk_addr(13'h4);
    #1 chk("c_snoop4", bus_if.snoop_data, 64'hC0C0_C0C0);
    bus_if.snoop_addr = '0;
    send(13'h3, 64'h333);
    tick();
    bus_if.wb_valid = 1'b0;
    chk("c_count3", 64'(bus_if.count), 64'd3);
    bus_if.mem_wr_accepted = 1'b1;
    repeat (3) tick();
    bus_if.mem_wr_accepted = 1'b0;
    chk("c_drained", 64'(bus_if.count), 64'd0);
`endif

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
